// File: rtl/blake_msg_buf_pkg.sv
// rtl/blake_msg_buf_pkg.sv - shared BLAKE word geometry and byte-swap helper
package blake_msg_buf_pkg;

    localparam int BLAKE_WORD_W = 64;
    localparam int BLAKE_NWORDS = 10;

    // Reverses the low nbytes bytes of w; upper bytes of the result are zero.
    function automatic logic [63:0] bswap_word(input logic [63:0] w, input int nbytes);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbytes) begin
                r[i*8 +: 8] = w[(nbytes-1-i)*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/blake_msg_buf_if.sv
// rtl/blake_msg_buf_if.sv - message block input stream (din/din_valid/din_ready)
interface blake_msg_buf_if #(
    parameter int MSG_W = blake_msg_buf_pkg::BLAKE_WORD_W * blake_msg_buf_pkg::BLAKE_NWORDS
) ();
    logic [MSG_W-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input  din_ready);
    modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/blake_msg_buf_fifo.sv
// rtl/blake_msg_buf_fifo.sv - slot storage with wrapping head/tail pointers and occupancy
module blake_msg_fifo #(
    parameter int W     = 640,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // A single-slot buffer keeps both pointers pinned at zero.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1 || p == PW'(DEPTH-1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb && push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata      = mem[rd_ptr_q];
    assign count      = count_q;
    assign count_next = rstb ? '0 : count_d;
endmodule

// File: rtl/blake_msg_buf.sv
// rtl/blake_msg_buf.sv - buffers message blocks and presents one per round to the BLAKE engine
module blake_msg_buf
    import blake_msg_buf_pkg::*;
#(
    parameter  int WORD_W     = BLAKE_WORD_W,
    parameter  int NWORDS     = BLAKE_NWORDS,
    parameter  int DEPTH      = 2,
    parameter  int SWAP_EN    = 1,
    parameter  int CLEAR_IDLE = 1,
    localparam int MSG_W      = WORD_W * NWORDS,
    localparam int CW         = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rstb,
    blake_msg_buf_if.slave    s_in,
    input  logic              init_round,
    input  logic              round_ing,
    output logic [MSG_W-1:0]  msg_out,
    output logic              msg_valid,
    output logic [CW-1:0]     count,
    output logic              underrun
);
    logic [MSG_W-1:0] din_sw;
    logic [MSG_W-1:0] fifo_rdata;
    logic [CW-1:0]    count_next;
    logic             push, pop;

    logic [MSG_W-1:0] msg_out_q, msg_out_d;
    logic             msg_valid_q, msg_valid_d;
    logic             underrun_q, underrun_d;
    logic             din_ready_q, din_ready_d;

    always_comb begin
        din_sw = s_in.din;
        if (SWAP_EN != 0) begin
            for (int w = 0; w < NWORDS; w++) begin
                din_sw[w*WORD_W +: WORD_W] =
                    WORD_W'(bswap_word(64'(s_in.din[w*WORD_W +: WORD_W]), WORD_W/8));
            end
        end
    end

    // din_ready is registered, so a pop never frees a slot for a push in the same cycle.
    assign push = s_in.din_valid && din_ready_q;
    assign pop  = init_round && (count != '0);

    blake_msg_fifo #(
        .W     (MSG_W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rstb       (rstb),
        .push       (push),
        .pop        (pop),
        .wdata      (din_sw),
        .rdata      (fifo_rdata),
        .count      (count),
        .count_next (count_next)
    );

    always_comb begin
        msg_out_d   = msg_out_q;
        msg_valid_d = msg_valid_q;
        if (init_round) begin
            if (count != '0) begin
                msg_out_d   = fifo_rdata;
                msg_valid_d = 1'b1;
            end
        end else if (!round_ing && CLEAR_IDLE != 0) begin
            msg_out_d   = '0;
            msg_valid_d = 1'b0;
        end
        underrun_d  = underrun_q || (init_round && count == '0);
        din_ready_d = count_next < CW'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            msg_out_q   <= '0;
            msg_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            din_ready_q <= 1'b0;
        end else begin
            msg_out_q   <= msg_out_d;
            msg_valid_q <= msg_valid_d;
            underrun_q  <= underrun_d;
            din_ready_q <= din_ready_d;
        end
    end

    assign s_in.din_ready = din_ready_q;
    assign msg_out        = msg_out_q;
    assign msg_valid      = msg_valid_q;
    assign underrun       = underrun_q;
endmodule

// File: tb/tb_blake_msg_buf.sv
// tb/tb_blake_msg_buf.sv - self-checking bench for blake_msg_buf
module tb_blake_msg_buf;
    localparam int WORD_W = 64;
    localparam int NWORDS = 10;
    localparam int MSG_W  = WORD_W * NWORDS;
    localparam int DEPTH  = 2;
    localparam int CW     = $clog2(DEPTH+1);

    logic clk = 1'b0;
    logic rstb;
    logic init_round;
    logic round_ing;

    blake_msg_buf_if #(.MSG_W(MSG_W)) if0 ();
    blake_msg_buf_if #(.MSG_W(MSG_W)) if1 ();

    logic [MSG_W-1:0] msg_out0, msg_out1;
    logic             msg_valid0, msg_valid1;
    logic [CW-1:0]    count0, count1;
    logic             underrun0, underrun1;

    assign if1.din       = if0.din;
    assign if1.din_valid = if0.din_valid;

    blake_msg_buf #(.DEPTH(DEPTH), .CLEAR_IDLE(1)) u0 (
        .clk(clk), .rstb(rstb), .s_in(if0.slave), .init_round(init_round),
        .round_ing(round_ing), .msg_out(msg_out0), .msg_valid(msg_valid0),
        .count(count0), .underrun(underrun0)
    );

    blake_msg_buf #(.DEPTH(DEPTH), .CLEAR_IDLE(0)) u1 (
        .clk(clk), .rstb(rstb), .s_in(if1.slave), .init_round(init_round),
        .round_ing(round_ing), .msg_out(msg_out1), .msg_valid(msg_valid1),
        .count(count1), .underrun(underrun1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] w0;
        logic [63:0] exp_w0;
    } vec_t;

    int tests  = 0;
    int failed = 0;

    logic [MSG_W-1:0] sb[$];
    logic [MSG_W-1:0] exp_msg, exp_msg1;
    logic             exp_valid, exp_valid1, exp_under, exp_ready;

    function automatic logic [MSG_W-1:0] model_swap(input logic [MSG_W-1:0] d);
        logic [MSG_W-1:0] r;
        for (int w = 0; w < NWORDS; w++)
            for (int b = 0; b < 8; b++)
                r[w*64 + b*8 +: 8] = d[w*64 + (7-b)*8 +: 8];
        return r;
    endfunction

    function automatic logic [MSG_W-1:0] mk_blk(input logic [63:0] w0);
        logic [MSG_W-1:0] r;
        r[63:0] = w0;
        for (int w = 1; w < NWORDS; w++) r[w*64 +: 64] = {$urandom, $urandom};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model advances on the same inputs the DUT sees at the coming edge, then outputs are sampled #1 later.
    task automatic step();
        logic [MSG_W-1:0] h;
        logic             do_push;
        if (rstb) begin
            sb.delete();
            exp_msg = '0; exp_valid = 1'b0; exp_msg1 = '0; exp_valid1 = 1'b0;
            exp_under = 1'b0; exp_ready = 1'b0;
        end else begin
            do_push = if0.din_valid && exp_ready;
            if (init_round) begin
                if (sb.size() > 0) begin
                    h = sb.pop_front();
                    exp_msg = h; exp_valid = 1'b1; exp_msg1 = h; exp_valid1 = 1'b1;
                end else begin
                    exp_under = 1'b1;
                end
            end else if (!round_ing) begin
                exp_msg = '0; exp_valid = 1'b0;
            end
            if (do_push) sb.push_back(model_swap(if0.din));
            exp_ready = sb.size() < DEPTH;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string t);
        chk({t, " msg_out"},    msg_out0,      exp_msg);
        chk({t, " msg_valid"},  msg_valid0,    exp_valid);
        chk({t, " count"},      count0,        sb.size());
        chk({t, " underrun"},   underrun0,     exp_under);
        chk({t, " din_ready"},  if0.din_ready, exp_ready);
        chk({t, " msg_out_ci0"},   msg_out1,   exp_msg1);
        chk({t, " msg_valid_ci0"}, msg_valid1, exp_valid1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        logic [MSG_W-1:0] blk_a, blk_b, blk_c;
        vecs[0] = '{64'h0011223344556677, 64'h7766554433221100};
        vecs[1] = '{64'h0123456789abcdef, 64'hefcdab8967452301};
        vecs[2] = '{64'hffffffff00000000, 64'h00000000ffffffff};
        vecs[3] = '{64'h8000000000000001, 64'h0100000000000080};

        rstb = 1'b1; init_round = 1'b0; round_ing = 1'b0;
        if0.din = '0; if0.din_valid = 1'b0;
        repeat (3) step();
        check_all("reset");
        rstb = 1'b0;
        step();
        check_all("post_reset");
        chk("din_ready_rise", if0.din_ready, 1'b1);

        // Byte-swap vectors: push, pop, then idle clears msg_out.
        for (int i = 0; i < 4; i++) begin
            if0.din = mk_blk(vecs[i].w0); if0.din_valid = 1'b1;
            step();
            if0.din_valid = 1'b0; init_round = 1'b1;
            step();
            init_round = 1'b0;
            check_all($sformatf("vec%0d pop", i));
            chk($sformatf("vec%0d word0", i), msg_out0[63:0], vecs[i].exp_w0);
            chk($sformatf("vec%0d valid", i), msg_valid0, 1'b1);
            step();
            check_all($sformatf("vec%0d idle", i));
        end

        // Full buffer stalls C until a pop frees a slot.
        blk_a = mk_blk(64'hA); blk_b = mk_blk(64'hB); blk_c = mk_blk(64'hC);
        round_ing = 1'b1;
        if0.din_valid = 1'b1;
        if0.din = blk_a; step(); check_all("push_a");
        if0.din = blk_b; step(); check_all("push_b");
        if0.din = blk_c; step(); check_all("stall_c");
        chk("stall din_ready", if0.din_ready, 1'b0);
        chk("stall count", count0, 2'd2);
        init_round = 1'b1; step(); check_all("pop_a");
        chk("pop_a data", msg_out0, model_swap(blk_a));
        chk("pop_a ready", if0.din_ready, 1'b1);
        init_round = 1'b0; step(); check_all("accept_c");
        chk("accept_c count", count0, 2'd2);
        if0.din_valid = 1'b0; init_round = 1'b1;
        step(); check_all("pop_b");
        chk("pop_b data", msg_out0, model_swap(blk_b));
        step(); check_all("pop_c");
        chk("pop_c data", msg_out0, model_swap(blk_c));

        // Underrun on empty pop is sticky; msg_out holds.
        step(); check_all("underrun");
        chk("underrun set", underrun0, 1'b1);
        chk("underrun hold data", msg_out0, model_swap(blk_c));
        init_round = 1'b0;
        repeat (3) begin step(); check_all("underrun_sticky"); end
        if0.din = mk_blk(64'hD); if0.din_valid = 1'b1; step(); check_all("push_d");
        if0.din_valid = 1'b0; init_round = 1'b1; step(); check_all("pop_d");
        init_round = 1'b0;

        // Round hold for 16 cycles, then idle behaviour per CLEAR_IDLE.
        if0.din = mk_blk(64'hE); if0.din_valid = 1'b1; step(); check_all("push_e");
        if0.din_valid = 1'b0; init_round = 1'b1; step(); check_all("pop_e");
        init_round = 1'b0; round_ing = 1'b1;
        for (int i = 0; i < 16; i++) begin step(); check_all($sformatf("hold%0d", i)); end
        round_ing = 1'b0; step(); check_all("idle_after_round");
        chk("clear_idle valid", msg_valid0, 1'b0);
        chk("clear_idle msg", msg_out0, '0);
        chk("no_clear valid", msg_valid1, 1'b1);

        // Simultaneous push and pop at count=1.
        round_ing = 1'b1;
        blk_a = mk_blk(64'hF); blk_b = mk_blk(64'h6);
        if0.din = blk_a; if0.din_valid = 1'b1; step(); check_all("push_f");
        if0.din = blk_b; init_round = 1'b1; step(); check_all("push_pop");
        chk("push_pop count", count0, 2'd1);
        chk("push_pop head", msg_out0, model_swap(blk_a));
        if0.din_valid = 1'b0; step(); check_all("pop_g");
        chk("pop_g data", msg_out0, model_swap(blk_b));
        init_round = 1'b0;

        // Reset mid-round with two blocks queued.
        if0.din_valid = 1'b1;
        if0.din = mk_blk(64'h1); step(); check_all("push_h");
        if0.din = mk_blk(64'h2); step(); check_all("push_i");
        chk("pre_reset count", count0, 2'd2);
        rstb = 1'b1; init_round = 1'b1; if0.din = mk_blk(64'h3);
        step(); check_all("mid_reset");
        chk("mid_reset valid", msg_valid0, 1'b0);
        chk("mid_reset count", count0, 2'd0);
        rstb = 1'b0; init_round = 1'b0; if0.din_valid = 1'b0; round_ing = 1'b0;
        step(); check_all("after_reset");
        init_round = 1'b1; step(); check_all("underrun_after_reset");
        chk("underrun_after_reset set", underrun0, 1'b1);
        init_round = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
